// File: rtl/homography_responder_pkg.sv
// Shared constants and types for the homography query responder.
// Contents: frame geometry, coefficient widths, cfg_sel codes, the packed
// coefficient set with its identity default, and RGB565 field positions.
package homography_responder_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned OFS_W    = 12;

  // RGB565 field slice positions
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [2:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4,
    SEL_F = 3'd5
  } cfg_sel_e;

  // A,B,D,E are signed Q8.8; C,F are signed integer pixel offsets
  typedef struct packed {
    logic signed [COEF_W-1:0] a;
    logic signed [COEF_W-1:0] b;
    logic signed [OFS_W-1:0]  c;
    logic signed [COEF_W-1:0] d;
    logic signed [COEF_W-1:0] e;
    logic signed [OFS_W-1:0]  f;
  } coef_t;

  localparam coef_t COEF_IDENTITY = '{
    a: 16'sh0100, b: '0, c: '0, d: '0, e: 16'sh0100, f: '0
  };

endpackage

// File: rtl/homography_affine_mac.sv
// One axis of the affine transform, two pipeline stages.
//   Stage A (first edge): products coef_x*x and coef_y*y (27-bit signed).
//   Stage B (second edge): sum, round-half-up /256, add offset, bounds test.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   x_i, y_i               unsigned query coordinates (zero-extended)
//   coef_x_i, coef_y_i     Q8.8 signed coefficients
//   ofs_i                  signed integer offset
//   coord_o                low 10 bits of the transformed coordinate
//   inb_o                  0 <= coordinate < LIMIT
module homography_affine_mac
  import homography_responder_pkg::*;
#(
  parameter int unsigned LIMIT = H_ACTIVE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [9:0]               x_i,
  input  logic [9:0]               y_i,
  input  logic signed [COEF_W-1:0] coef_x_i,
  input  logic signed [COEF_W-1:0] coef_y_i,
  input  logic signed [OFS_W-1:0]  ofs_i,
  output logic [9:0]               coord_o,
  output logic                     inb_o
);

  logic signed [26:0] prod_x_d, prod_y_d, prod_x_q, prod_y_q;
  logic signed [27:0] sum_d, rnd_d, pos_d;
  logic [9:0]         coord_d, coord_q;
  logic               inb_d, inb_q;

  assign prod_x_d = coef_x_i * $signed({1'b0, x_i});
  assign prod_y_d = coef_y_i * $signed({1'b0, y_i});

  always_comb begin
    sum_d   = 28'(prod_x_q) + 28'(prod_y_q);
    rnd_d   = (sum_d + 28'sd128) >>> 8;
    pos_d   = rnd_d + 28'(ofs_i);
    // sign bit clear means non-negative; the magnitude compare is then unsigned
    inb_d   = !pos_d[27] && (pos_d[26:0] < 27'(LIMIT));
    coord_d = pos_d[9:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_x_q <= '0;
      prod_y_q <= '0;
      coord_q  <= '0;
      inb_q    <= 1'b0;
    end else begin
      prod_x_q <= prod_x_d;
      prod_y_q <= prod_y_d;
      coord_q  <= coord_d;
      inb_q    <= inb_d;
    end
  end

  assign coord_o = coord_q;
  assign inb_o   = inb_q;

endmodule

// File: rtl/homography_responder.sv
// Responder end of the homography query interface.
// Each (query_x, query_y) sampled with start is mapped through the active
// affine transform, the source pixel is read from a 640x480 RGB565 frame
// store, and the echoed query plus pixel come back with ready exactly five
// cycles after start. Out-of-bounds queries skip the read and return black.
// Ports:
//   clk_25, rst_n                 clock, async active-low reset
//   start, query_x, query_y       query in (one per cycle, no backpressure)
//   return_x, return_y, r, g, b   response, held while ready=0
//   ready                         one-cycle pulse per response
//   mem_addr, mem_rden, mem_q     frame store read port (1-cycle latency)
//   cfg_we, cfg_sel, cfg_data     shadow coefficient write
//   cfg_commit, cfg_busy          shadow-to-active commit and pending flag
module homography_responder
  import homography_responder_pkg::*;
(
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  query_x,
  input  logic [9:0]  query_y,
  output logic [9:0]  return_x,
  output logic [9:0]  return_y,
  output logic [4:0]  r,
  output logic [5:0]  g,
  output logic [4:0]  b,
  output logic        ready,
  output logic [18:0] mem_addr,
  output logic        mem_rden,
  input  logic [15:0] mem_q,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_sel,
  input  logic [15:0] cfg_data,
  input  logic        cfg_commit,
  output logic        cfg_busy
);

  // Pipeline: index 0..4 = S1..S5
  logic [4:0] valid_q;
  logic [9:0] qx_q [5];
  logic [9:0] qy_q [5];

  coef_t shadow_q, shadow_d, active_q, active_d;
  logic  pending_q, pending_d, load;

  logic [9:0]  sx, sy;
  logic        inb_x, inb_y;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic        mem_rden_q, mem_rden_d;
  logic        inb5_q;

  logic        ready_q;
  logic [9:0]  ret_x_q, ret_y_q;
  logic [4:0]  r_q, r_d, b_q, b_d;
  logic [5:0]  g_q, g_d;

  homography_affine_mac #(.LIMIT(H_ACTIVE)) u_mac_x (
    .clk_i    (clk_25),
    .rst_ni   (rst_n),
    .x_i      (qx_q[0]),
    .y_i      (qy_q[0]),
    .coef_x_i (active_q.a),
    .coef_y_i (active_q.b),
    .ofs_i    (active_q.c),
    .coord_o  (sx),
    .inb_o    (inb_x)
  );

  homography_affine_mac #(.LIMIT(V_ACTIVE)) u_mac_y (
    .clk_i    (clk_25),
    .rst_ni   (rst_n),
    .x_i      (qx_q[0]),
    .y_i      (qy_q[0]),
    .coef_x_i (active_q.d),
    .coef_y_i (active_q.e),
    .ofs_i    (active_q.f),
    .coord_o  (sy),
    .inb_o    (inb_y)
  );

  // Coefficient shadow/commit. The load uses shadow_d so a write landing on
  // the load edge (including one paired with its own commit) is included.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) begin
      case (cfg_sel)
        SEL_A:   shadow_d.a = cfg_data;
        SEL_B:   shadow_d.b = cfg_data;
        SEL_C:   shadow_d.c = cfg_data[OFS_W-1:0];
        SEL_D:   shadow_d.d = cfg_data;
        SEL_E:   shadow_d.e = cfg_data;
        SEL_F:   shadow_d.f = cfg_data[OFS_W-1:0];
        default: ;
      endcase
    end
    // S1..S4 all read the active set; S5 no longer does
    load      = pending_q && (valid_q[3:0] == '0) && !start;
    active_d  = load ? shadow_d : active_q;
    pending_d = load ? 1'b0 : (pending_q | cfg_commit);
  end

  always_comb begin
    mem_rden_d = valid_q[2] && inb_x && inb_y;
    mem_addr_d = mem_rden_d ? ((19'(sy) << 9) + (19'(sy) << 7) + 19'(sx))
                            : mem_addr_q;
    if (inb5_q) begin
      r_d = mem_q[R_MSB:R_LSB];
      g_d = mem_q[G_MSB:G_LSB];
      b_d = mem_q[B_MSB:B_LSB];
    end else begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      for (int unsigned i = 0; i < 5; i++) begin
        qx_q[i] <= '0;
        qy_q[i] <= '0;
      end
      shadow_q   <= COEF_IDENTITY;
      active_q   <= COEF_IDENTITY;
      pending_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_rden_q <= 1'b0;
      inb5_q     <= 1'b0;
      ready_q    <= 1'b0;
      ret_x_q    <= '0;
      ret_y_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      valid_q <= {valid_q[3:0], start};
      qx_q[0] <= query_x;
      qy_q[0] <= query_y;
      for (int unsigned i = 1; i < 5; i++) begin
        qx_q[i] <= qx_q[i-1];
        qy_q[i] <= qy_q[i-1];
      end
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      mem_addr_q <= mem_addr_d;
      mem_rden_q <= mem_rden_d;
      inb5_q     <= mem_rden_q;
      ready_q    <= valid_q[4];
      if (valid_q[4]) begin
        ret_x_q <= qx_q[4];
        ret_y_q <= qy_q[4];
        r_q     <= r_d;
        g_q     <= g_d;
        b_q     <= b_d;
      end
    end
  end

  assign return_x = ret_x_q;
  assign return_y = ret_y_q;
  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign ready    = ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_rden = mem_rden_q;
  assign cfg_busy = pending_q;

endmodule

// File: tb/tb_homography_responder.sv
module tb_homography_responder;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  query_x, query_y;
  logic [9:0]  return_x, return_y;
  logic [4:0]  r, b;
  logic [5:0]  g;
  logic        ready;
  logic [18:0] mem_addr;
  logic        mem_rden;
  logic [15:0] mem_q;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;

  always #20 clk_25 = ~clk_25;

  homography_responder dut (
    .clk_25     (clk_25),
    .rst_n      (rst_n),
    .start      (start),
    .query_x    (query_x),
    .query_y    (query_y),
    .return_x   (return_x),
    .return_y   (return_y),
    .r          (r),
    .g          (g),
    .b          (b),
    .ready      (ready),
    .mem_addr   (mem_addr),
    .mem_rden   (mem_rden),
    .mem_q      (mem_q),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit const_mode = 1'b1;

  typedef struct { int x; int y; int r; int g; int b; int cyc; } resp_t;
  typedef struct { int addr; int cyc; } acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];

  // Reference coefficient state, index = cfg_sel code (A,B,C,D,E,F)
  logic [15:0] sh [6];
  logic [15:0] act[6];
  bit          pending;
  logic [3:0]  recent_starts;

  // Frame store contents as a function of address
  function automatic logic [15:0] pix(int addr);
    int unsigned h;
    if (const_mode) return 16'hF81F;
    h = int'(addr) * 32'd2654435761;
    return h[31:16];
  endfunction

  // floor((cx*x + cy*y + 128)/256) + ofs, all in plain signed integers
  function automatic longint axis(logic [15:0] cx, logic [15:0] cy,
                                  logic [15:0] co, int x, int y);
    shortint            sx = cx;
    shortint            sy = cy;
    logic signed [11:0] so = co[11:0];
    longint t, q;
    t = longint'(sx) * x + longint'(sy) * y + 128;
    q = t / 256;
    if (t < 0 && (t % 256) != 0) q = q - 1;
    return q + longint'(so);
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      sh[i]  = (i == 0 || i == 4) ? 16'h0100 : 16'h0000;
      act[i] = sh[i];
    end
    pending       = 1'b0;
    recent_starts = '0;
    resp_q.delete();
    acc_q.delete();
  endtask

  // One clock edge: advance the reference model with the inputs the DUT sampled
  task automatic tick();
    logic [15:0] nsh[6];
    bit          load;
    longint      ex, ey;
    logic [15:0] p;
    resp_t       e;
    acc_t        a;
    @(posedge clk_25);
    cyc++;
    if (rst_n) begin
      load = pending && !start && (recent_starts == 4'd0);
      nsh  = sh;
      if (cfg_we && cfg_sel < 3'd6) nsh[cfg_sel] = cfg_data;
      if (load) begin
        act     = nsh;
        pending = 1'b0;
      end else if (cfg_commit) pending = 1'b1;
      sh = nsh;
      if (start) begin
        ex = axis(act[0], act[1], act[2], int'(query_x), int'(query_y));
        ey = axis(act[3], act[4], act[5], int'(query_x), int'(query_y));
        e.x = int'(query_x); e.y = int'(query_y); e.cyc = cyc + 5;
        if (ex >= 0 && ex < 640 && ey >= 0 && ey < 480) begin
          a.addr = int'(ey * 640 + ex);
          a.cyc  = cyc + 3;
          acc_q.push_back(a);
          p   = pix(a.addr);
          e.r = int'(p[15:11]); e.g = int'(p[10:5]); e.b = int'(p[4:0]);
        end else begin
          e.r = 0; e.g = 0; e.b = 0;
        end
        resp_q.push_back(e);
      end
      recent_starts = {recent_starts[2:0], start};
    end
    #1;
  endtask

  task automatic idle(int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(int x, int y);
    start = 1'b1; query_x = 10'(x); query_y = 10'(y);
    tick();
    start = 1'b0;
  endtask

  task automatic cfg(int sel, int data, bit commit);
    cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_data = 16'(data); cfg_commit = commit;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 40 && cfg_busy === 1'b1; i++) tick();
    chk("commit_done", cfg_busy, 0);
  endtask

  // Frame store: read data valid one cycle after mem_rden
  always @(posedge clk_25) if (mem_rden) mem_q <= pix(int'(mem_addr));

  // Monitor / scoreboard
  logic [35:0] last_out = '0;
  always @(negedge clk_25) begin
    resp_t e;
    acc_t  a;
    if (!rst_n) begin
      chk("reset_outputs", longint'({ready, mem_rden, mem_addr, return_x, return_y,
                                     r, g, b, cfg_busy}), 0);
      last_out = '0;
    end else begin
      chk("cfg_busy", cfg_busy, pending);
      if (mem_rden) begin
        if (acc_q.size() == 0) chk("unexpected_rden", 1, 0);
        else begin
          a = acc_q.pop_front();
          chk("mem_addr", mem_addr, a.addr);
          chk("rden_cycle", cyc, a.cyc);
        end
      end
      if (ready) begin
        if (resp_q.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          e = resp_q.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("return_x", return_x, e.x);
          chk("return_y", return_y, e.y);
          chk("r", r, e.r);
          chk("g", g, e.g);
          chk("b", b, e.b);
          last_out = {10'(e.x), 10'(e.y), 5'(e.r), 6'(e.g), 5'(e.b)};
        end
      end else begin
        chk("hold", longint'({return_x, return_y, r, g, b}), longint'(last_out));
      end
    end
  end

  initial begin
    start = 0; query_x = 0; query_y = 0;
    cfg_we = 0; cfg_sel = 0; cfg_data = 0; cfg_commit = 0;
    mem_q = 0;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    model_reset();
    tick(); tick(); tick();
    rst_n = 1'b1;
    idle(2);

    // Identity: (10,20) -> address 12810, magenta pixel
    const_mode = 1'b1;
    issue(10, 20);
    idle(8);

    // C = 700 pushes every x out of frame
    cfg(2, 700, 1'b1);
    wait_commit();
    issue(5, 5);
    idle(8);

    // A = 0.5, C = 0: (3,0) -> sx = round(1.5) = 2
    cfg(2, 0, 1'b0);
    cfg(0, 16'h0080, 1'b1);
    wait_commit();
    issue(3, 0);
    idle(8);

    // Back to identity, then three back-to-back queries
    cfg(0, 16'h0100, 1'b1);
    wait_commit();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; query_x = 10'(i); query_y = 10'd0;
      tick();
    end
    idle(8);

    // Commit while queries are in flight and start stays high
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; query_x = 10'(40 + i); query_y = 10'(30 + i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; query_x = 10'(50 + i); query_y = 10'(60 + i);
      if (i == 0) begin
        cfg_we = 1'b1; cfg_sel = 3'd4; cfg_data = 16'h0200; cfg_commit = 1'b1;
      end
      tick();
      cfg_we = 1'b0; cfg_commit = 1'b0;
      chk("busy_while_streaming", cfg_busy, 1);
    end
    start = 1'b0;
    wait_commit();
    issue(60, 100);
    idle(8);
    cfg(4, 16'h0100, 1'b1);
    wait_commit();

    // Randomized traffic with random coefficient updates
    const_mode = 1'b0;
    idle(1);
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 9) < 7);
      query_x = 10'($urandom_range(0, 720));
      query_y = 10'($urandom_range(0, 540));
      if ($urandom_range(0, 19) == 0) begin
        cfg_we  = 1'b1;
        cfg_sel = 3'($urandom_range(0, 7));
        case (cfg_sel)
          3'd0, 3'd4: cfg_data = 16'(int'($urandom_range(0, 160)) + 176);
          3'd1, 3'd3: cfg_data = 16'(int'($urandom_range(0, 64)) - 32);
          3'd2, 3'd5: cfg_data = 16'(int'($urandom_range(0, 200)) - 100);
          default:    cfg_data = 16'($urandom());
        endcase
      end
      cfg_commit = ($urandom_range(0, 29) == 0);
      tick();
      cfg_we = 1'b0; cfg_commit = 1'b0;
    end
    idle(10);
    wait_commit();

    // Asynchronous reset two cycles after a start: response is dropped,
    // coefficients return to identity
    const_mode = 1'b1;
    cfg(0, 16'h0180, 1'b1);
    wait_commit();
    issue(7, 9);
    tick(); tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    idle(8);
    issue(100, 50);
    idle(8);

    chk("responses_drained", resp_q.size(), 0);
    chk("reads_drained", acc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/homography_responder.md
Name: homography_responder

Overview:
- Responder end of the homography query interface: accepts one (query_x, query_y) per cycle on start.
- Maps each query through an affine coordinate transform into a 640x480 RGB565 frame store and fetches the source pixel.
- Returns return_x/return_y and r/g/b with ready at a fixed 5-cycle latency, matching the 5-deep alignment buffer on the requesting side.
- Coefficients are loaded through a shadow/commit config port so a write never changes the transform mid-flight.

Parameters:
- H_ACTIVE, 640, frame width in pixels.
- V_ACTIVE, 480, frame height in pixels.
- COEF_W, 16, width of signed Q8.8 matrix coefficients A, B, D, E.
- OFS_W, 12, width of signed integer pixel offsets C, F.

Ports:
- clk_25  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  query valid, sampled every rising edge.
- query_x  in  10  destination x.
- query_y  in  10  destination y.
- return_x  out  10  echoed query_x.
- return_y  out  10  echoed query_y.
- r  out  5  pixel red.
- g  out  6  pixel green.
- b  out  5  pixel blue.
- ready  out  1  one-cycle pulse per returned query.
- mem_addr  out  19  frame store read address, sy*640+sx.
- mem_rden  out  1  frame store read enable.
- mem_q  in  16  RGB565 read data, valid 1 cycle after mem_rden.
- cfg_we  in  1  shadow coefficient write.
- cfg_sel  in  3  select: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F; 6 and 7 are ignored.
- cfg_data  in  16  write data; C and F use bits [11:0].
- cfg_commit  in  1  request copy of shadow to active coefficients.
- cfg_busy  out  1  commit pending.

Behaviour:
- Transform:
  - sx = round((A*x + B*y) / 256) + C
  - sy = round((D*x + E*y) / 256) + F
  - x and y are zero-extended. Products are 27-bit signed; the sum is 28-bit.
  - Rounding is add 128 then arithmetic shift right by 8 (round-half-up). The offset is sign-extended before the add.
- In-bounds test: 0 <= sx < H_ACTIVE and 0 <= sy < V_ACTIVE.
  - In bounds: mem_rden=1 and mem_addr = (sy<<9)+(sy<<7)+sx.
  - Out of bounds: mem_rden=0, and the returned pixel is r=g=b=0.
- Pipeline timing, with start sampled at edge k:
  - S1 (edge k): register query and valid.
  - S2 (edge k+1): register products.
  - S3 (edge k+2): register sum, rounding, offset and bounds flag.
  - S4 (edge k+3): register mem_addr and mem_rden.
  - S5 (edge k+4 to k+5): capture mem_q. Outputs are registered at edge k+5, so ready is high for exactly one cycle after edge k+5.
- Throughput and ordering: one query per cycle; no backpressure; responses come back in order. Back-to-back starts give back-to-back ready pulses.
- Output hold: return_x/y and r/g/b hold their last values while ready=0. mem_rden is 0 whenever S4 has no valid query.
- RGB565 decode: r=mem_q[15:11], g=mem_q[10:5], b=mem_q[4:0].
- Config:
  - cfg_we writes shadow[cfg_sel].
  - cfg_commit sets pending. Active coefficients are loaded from shadow on the first edge at which pending=1, S1..S4 hold no valid query, and start=0.
  - cfg_busy = pending.
  - cfg_we and cfg_commit in the same cycle: the commit includes that write.
  - A commit issued while pending is already set has no additional effect.
- Reset (asynchronous, any time, including mid-operation):
  - All pipeline valid bits are cleared, so no ready is produced for in-flight queries.
  - ready=0, mem_rden=0, mem_addr=0, return_x/y=0, r/g/b=0, cfg_busy=0.
  - Active and shadow coefficients go to identity: A=E=16'h0100, B=D=0, C=F=0.

Decomposition:
- Shared package:
  - constants H_ACTIVE, V_ACTIVE, COEF_W, OFS_W;
  - cfg_sel codes;
  - identity coefficient defaults;
  - RGB565 field slice positions.
  The requesting controller reuses the frame constants and RGB565 slices.
- One sub-module, homography_affine_mac: stages S2–S3 for one axis (two products, sum, round, offset, bounds compare). Instantiate it twice, once for x and once for y.

Test Plan:
- Identity transform, mem_q=16'hF81F, single start with query (10,20) -> mem_rden=1 with mem_addr=12810 at S4; ready exactly 5 cycles after start; return (10,20); r=31, g=0, b=31.
- Commit C=700 via cfg_sel=2 and cfg_data=700, then query (5,5) -> mem_rden never asserted; ready after 5 cycles with r=g=b=0 and return (5,5).
- A=16'h0080 (0.5) committed, query (3,0) -> sx=round(1.5)=2; mem_addr=2.
- Starts on 3 consecutive cycles with queries (0,0), (1,0), (2,0) -> ready high for 3 consecutive cycles with return_x=0, 1, 2 in order.
- cfg_commit while 2 queries are in flight and start held high for 4 more cycles -> cfg_busy=1 until the pipeline drains with start low; in-flight queries use the old coefficients; cfg_busy returns to 0 on the load edge.
- Assert rst_n=0 for 1 cycle, 2 cycles after a start -> no ready pulse follows; all outputs 0; coefficients back to identity.
